cp0_unit: RTL and testbench

- Parametrised coprocessor-0 for the 5-stage MIPS pipeline; sits beside the M stage.
- Holds SR(12), Cause(13), EPC(14) and PRId(15), plus an optional Count(9)/Compare(11) timer.
- Latches exception entry: EPC, exception code, BD bit and pending-interrupt bits. Clears EXL on eret.
- Generates a masked interrupt request for the pipeline's exception logic. Supports 1..6 hardware interrupt lines.

---
 rtl/cp0_pkg.sv | 43 ++++
 rtl/cp0_timer.sv | 62 ++++++
 rtl/cp0_unit.sv | 179 +++++++++++++++++
 tb/tb_cp0_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 slice: register indices, bit
// positions inside SR/Cause and the exception codes used by the pipeline.
// The optional Count/Compare timer is enabled with the CP0_TIMER_EN macro.
package cp0_pkg;

  // CP0 register indices (mfc0/mtc0 rd field)
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  // Bit positions inside SR and Cause
  localparam int SR_IE   = 0;
  localparam int SR_EXL  = 1;
  localparam int IM_LSB  = 10;
  localparam int IP_LSB  = 10;
  localparam int TIE_BIT = 30;
  localparam int TI_BIT  = 30;
  localparam int BD_BIT  = 31;
  localparam int EXC_LSB = 2;

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Restart address for an exception: a delay-slot instruction restarts at
  // its branch, and EPC is always word aligned.
  function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic bd);
    logic [31:0] target;
    if (bd) begin
      target = pc - 32'd4;
    end else begin
      target = pc;
    end
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for coprocessor 0. Count free-runs and wraps; a match
// between the next Count value and Compare sets the sticky TI flag, and any
// write to Compare clears it (the clear beats a simultaneous match).
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q,      ti_d;

  // Next-state for Count, Compare and the timer interrupt flag
  always_comb begin
    if (count_we_i) begin
      count_d = wdata_i;
    end else begin
      count_d = count_q + 32'd1;
    end

    if (compare_we_i) begin
      compare_d = wdata_i;
    end else begin
      compare_d = compare_q;
    end

    if (compare_we_i) begin
      ti_d = 1'b0;
    end else if (count_d == compare_q) begin
      ti_d = 1'b1;
    end else begin
      ti_d = ti_q;
    end
  end

  // Timer state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 beside the M stage: SR, Cause, EPC, PRId and (optionally)
// the Count/Compare timer. Records exception entry, clears EXL on eret and
// produces the masked interrupt request for the pipeline.
// Optional feature macro: CP0_TIMER_EN (adds Count/Compare/TI/TIE).
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter logic [31:0] PRID_VAL   = 32'h0000_4C32,
  parameter int          EXC_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            addr,
  input  logic [31:0]           wdata,
  input  logic                  we,
  output logic [31:0]           rdata,
  input  logic [31:0]           pc_m,
  input  logic                  bd_m,
  input  logic                  exc_valid,
  input  logic [EXC_W-1:0]      exc_code,
  input  logic                  eret,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic [31:0]           epc,
  output logic                  exl,
  output logic                  ie,
  output logic [NUM_HW_INT-1:0] im,
  output logic                  int_req
);

  // SR fields
  logic                  ie_q,   ie_d;
  logic                  exl_q,  exl_d;
  logic [NUM_HW_INT-1:0] im_q,   im_d;
  logic                  tie_q,  tie_d;
  // Cause fields
  logic                  bd_q,   bd_d;
  logic [EXC_W-1:0]      code_q, code_d;
  logic [NUM_HW_INT-1:0] ip_q,   ip_d;
  // EPC, word aligned so only [31:2] is stored
  logic [29:0]           epc_q,  epc_d;

  logic [31:0] exc_pc_s;
  logic [31:0] sr_s;
  logic [31:0] cause_s;
  logic [31:0] count_s;
  logic [31:0] compare_s;
  logic        ti_s;
  logic        unused_s;

  assign exc_pc_s = exc_epc(pc_m, bd_m);

`ifdef CP0_TIMER_EN
  // A timer write only lands when neither exception entry nor eret claims the edge
  logic wr_ok_s;
  assign wr_ok_s = we & ~exc_valid & ~eret;

  cp0_timer u_timer (
    .clk_i        (clk),
    .reset_i      (reset),
    .count_we_i   (wr_ok_s && (addr == CP0_COUNT)),
    .compare_we_i (wr_ok_s && (addr == CP0_COMPARE)),
    .wdata_i      (wdata),
    .count_o      (count_s),
    .compare_o    (compare_s),
    .ti_o         (ti_s)
  );
`else
  assign count_s   = 32'd0;
  assign compare_s = 32'd0;
  assign ti_s      = 1'b0;
`endif

  // Low address/data bits that never reach architectural state
  assign unused_s = ^{wdata[1:0], exc_pc_s[1:0]};

  // Next-state for SR/Cause/EPC: exception entry beats eret, which beats mtc0
  always_comb begin
    ie_d   = ie_q;
    exl_d  = exl_q;
    im_d   = im_q;
    tie_d  = tie_q;
    bd_d   = bd_q;
    code_d = code_q;
    epc_d  = epc_q;
    // Pending lines are a plain level copy every cycle
    ip_d   = hw_int;

    if (exc_valid) begin
      epc_d  = exc_pc_s[31:2];
      bd_d   = bd_m;
      code_d = exc_code;
      exl_d  = 1'b1;
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (we) begin
      case (addr)
        CP0_SR: begin
          ie_d  = wdata[SR_IE];
          exl_d = wdata[SR_EXL];
          im_d  = wdata[IM_LSB +: NUM_HW_INT];
`ifdef CP0_TIMER_EN
          tie_d = wdata[TIE_BIT];
`else
          tie_d = 1'b0;
`endif
        end
        CP0_EPC: begin
          epc_d = wdata[31:2];
        end
        default: begin
          // Cause and PRId are read-only; other indices have no state here
        end
      endcase
    end else begin
      // No event this cycle: hold everything except the sampled lines
    end
  end

  // Architectural register state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q   <= 1'b0;
      exl_q  <= 1'b0;
      im_q   <= '0;
      tie_q  <= 1'b0;
      bd_q   <= 1'b0;
      code_q <= '0;
      ip_q   <= '0;
      epc_q  <= 30'd0;
    end else begin
      ie_q   <= ie_d;
      exl_q  <= exl_d;
      im_q   <= im_d;
      tie_q  <= tie_d;
      bd_q   <= bd_d;
      code_q <= code_d;
      ip_q   <= ip_d;
      epc_q  <= epc_d;
    end
  end

  // Assemble the software-visible SR and Cause images
  always_comb begin
    sr_s                          = 32'd0;
    sr_s[SR_IE]                   = ie_q;
    sr_s[SR_EXL]                  = exl_q;
    sr_s[IM_LSB +: NUM_HW_INT]    = im_q;
    sr_s[TIE_BIT]                 = tie_q;

    cause_s                       = 32'd0;
    cause_s[BD_BIT]               = bd_q;
    cause_s[TI_BIT]               = ti_s;
    cause_s[IP_LSB +: NUM_HW_INT] = ip_q;
    cause_s[EXC_LSB +: EXC_W]     = code_q;
  end

  // mfc0 read mux, zero latency from addr
  always_comb begin
    case (addr)
      CP0_SR:      rdata = sr_s;
      CP0_CAUSE:   rdata = cause_s;
      CP0_EPC:     rdata = {epc_q, 2'b00};
      CP0_PRID:    rdata = PRID_VAL;
      CP0_COUNT:   rdata = count_s;
      CP0_COMPARE: rdata = compare_s;
      default:     rdata = 32'd0;
    endcase
  end

  assign epc = {epc_q, 2'b00};
  assign exl = exl_q;
  assign ie  = ie_q;
  assign im  = im_q;

  // Interrupt request is suppressed while in exception level or with IE clear
  assign int_req = ie_q & ~exl_q & ((|(ip_q & im_q)) | (ti_s & tie_q));

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus a randomized run,
// all compared against a register-image reference model built from the
// architectural rules (write masks, priority of events, timer behaviour).
module tb_cp0_unit;
  import cp0_pkg::*;

  localparam int          N    = 6;
  localparam logic [31:0] PRID = 32'h0000_4C32;
`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    addr;
  logic [31:0]   wdata;
  logic          we;
  logic [31:0]   rdata;
  logic [31:0]   pc_m;
  logic          bd_m;
  logic          exc_valid;
  logic [4:0]    exc_code;
  logic          eret;
  logic [N-1:0]  hw_int;
  logic [31:0]   epc;
  logic          exl;
  logic          ie;
  logic [N-1:0]  im;
  logic          int_req;

  int checks = 0;
  int errors = 0;

  // Reference model: full 32-bit register images
  logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;

  cp0_unit #(.NUM_HW_INT(N), .PRID_VAL(PRID), .EXC_W(5)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
    .pc_m(pc_m), .bd_m(bd_m), .exc_valid(exc_valid), .exc_code(exc_code),
    .eret(eret), .hw_int(hw_int), .epc(epc), .exl(exl), .ie(ie), .im(im),
    .int_req(int_req)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_int_req();
    logic [31:0] ipmask;
    ipmask = ((32'd1 << N) - 32'd1) << 10;
    return m_sr[0] & ~m_sr[1] &
           ((|(m_cause & m_sr & ipmask)) | (m_cause[30] & m_sr[30]));
  endfunction

  // Advance one clock: the model consumes the inputs held during the cycle
  task automatic cycle();
    logic [31:0] nsr, ncause, nepc, ncount, ncompare, ipmask, srw;
    logic        wr;
    ipmask   = ((32'd1 << N) - 32'd1) << 10;
    srw      = 32'h0000_0003 | ipmask | (TIMER ? 32'h4000_0000 : 32'h0);
    nsr      = m_sr;
    nepc     = m_epc;
    ncount   = m_count;
    ncompare = m_compare;
    wr       = we && !exc_valid && !eret;
    ncause   = (m_cause & ~ipmask) | (32'(hw_int) << 10);
    if (TIMER) begin
      ncount = (wr && addr == 5'd9) ? wdata : m_count + 32'd1;
      if (ncount == m_compare) ncause[30] = 1'b1;
      if (wr && addr == 5'd11) begin
        ncompare   = wdata;
        ncause[30] = 1'b0;
      end
    end
    if (exc_valid) begin
      nepc   = (bd_m ? pc_m - 32'd4 : pc_m) & 32'hFFFF_FFFC;
      ncause = (ncause & ~32'h8000_007C) | (32'(bd_m) << 31) | (32'(exc_code) << 2);
      nsr[1] = 1'b1;
    end else if (eret) begin
      nsr[1] = 1'b0;
    end else if (we) begin
      if (addr == 5'd12) nsr = wdata & srw;
      if (addr == 5'd14) nepc = wdata & 32'hFFFF_FFFC;
    end
    if (reset) begin
      nsr = 0; ncause = 0; nepc = 0; ncount = 0; ncompare = 0;
    end
    @(posedge clk);
    #1;
    m_sr = nsr; m_cause = ncause; m_epc = nepc; m_count = ncount; m_compare = ncompare;
  endtask

  task automatic idle();
    reset = 1'b0; we = 1'b0; exc_valid = 1'b0; eret = 1'b0;
    bd_m = 1'b0; pc_m = 32'd0; exc_code = 5'd0; wdata = 32'd0;
  endtask

  task automatic peek(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    cycle();
    we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    idle(); hw_int = '0; addr = 5'd0; reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    peek(5'd12, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_sr got %h exp %h", d, 32'h0); end
    peek(5'd13, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cause got %h exp %h", d, 32'h0); end
    peek(5'd14, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp %h", d, 32'h0); end
    peek(5'd15, d); checks++; if (d !== PRID) begin errors++; $display("FAIL reset_prid got %h exp %h", d, PRID); end
    checks++; if ({int_req, exl, ie, im, epc} !== '0) begin
      errors++; $display("FAIL reset_outs got %b %b %b %h %h exp zeros", int_req, exl, ie, im, epc);
    end
  endtask

  task automatic test_interrupt();
    logic [31:0] d;
    mtc0(5'd12, 32'h0000_0401);
    checks++; if (ie !== 1'b1 || im !== 6'h01) begin errors++; $display("FAIL sr_write got ie=%b im=%h exp ie=1 im=01", ie, im); end
    hw_int = 6'h01;
    #1;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL int_latency got %b exp 0", int_req); end
    cycle();
    peek(5'd13, d);
    checks++; if (d !== 32'h0000_0400) begin errors++; $display("FAIL cause_ip got %h exp %h", d, 32'h0000_0400); end
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL int_req_set got %b exp 1", int_req); end
    hw_int = 6'h02;
    cycle();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL int_masked got %b exp 0", int_req); end
    hw_int = 6'h00;
    cycle();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL int_drop got %b exp 0", int_req); end
  endtask

  task automatic test_exception();
    logic [31:0] d;
    exc_valid = 1'b1; exc_code = EXC_OV; pc_m = 32'h3010; bd_m = 1'b1;
    we = 1'b1; addr = 5'd14; wdata = 32'h5000;
    cycle();
    idle();
    checks++; if (epc !== 32'h300C) begin errors++; $display("FAIL exc_epc got %h exp %h", epc, 32'h300C); end
    peek(5'd13, d);
    checks++; if (d !== 32'h8000_0030) begin errors++; $display("FAIL exc_cause got %h exp %h", d, 32'h8000_0030); end
    checks++; if (exl !== 1'b1 || int_req !== 1'b0) begin errors++; $display("FAIL exc_exl got exl=%b irq=%b exp 1 0", exl, int_req); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    peek(5'd13, d);
    checks++; if (d !== 32'h8000_0030) begin errors++; $display("FAIL cause_ro got %h exp %h", d, 32'h8000_0030); end
    mtc0(5'd15, 32'h0);
    peek(5'd15, d);
    checks++; if (d !== PRID) begin errors++; $display("FAIL prid_ro got %h exp %h", d, PRID); end
    // Nested entry overwrites EPC, BD and code
    exc_valid = 1'b1; exc_code = EXC_RI; pc_m = 32'h0000_1237; bd_m = 1'b0;
    cycle();
    idle();
    peek(5'd13, d);
    checks++; if (epc !== 32'h1234 || d !== 32'h0000_0028) begin
      errors++; $display("FAIL nested_exc got epc=%h cause=%h exp 00001234 00000028", epc, d);
    end
  endtask

  task automatic test_eret();
    logic [31:0] d;
    eret = 1'b1;
    cycle();
    idle();
    checks++; if (exl !== 1'b0 || int_req !== 1'b0) begin errors++; $display("FAIL eret got exl=%b irq=%b exp 0 0", exl, int_req); end
    exc_valid = 1'b1; exc_code = EXC_ADEL; pc_m = 32'h100;
    cycle();
    idle();
    eret = 1'b1; we = 1'b1; addr = 5'd12; wdata = 32'h0000_0000;
    cycle();
    idle();
    peek(5'd12, d);
    checks++; if (d !== 32'h0000_0401) begin errors++; $display("FAIL eret_we got %h exp %h", d, 32'h0000_0401); end
    exc_valid = 1'b1; eret = 1'b1; exc_code = EXC_ADES; pc_m = 32'h200;
    cycle();
    idle();
    checks++; if (exl !== 1'b1) begin errors++; $display("FAIL exc_eret got %b exp 1", exl); end
    eret = 1'b1;
    cycle();
    idle();
    mtc0(5'd14, 32'h1234_5677);
    checks++; if (epc !== 32'h1234_5674) begin errors++; $display("FAIL epc_write got %h exp %h", epc, 32'h1234_5674); end
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    logic [31:0] d, c;
    mtc0(5'd12, 32'h4000_0001);
    mtc0(5'd11, 32'h1);
    mtc0(5'd9, 32'hFFFF_FFFE);
    peek(5'd9, d);
    checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cnt_load got %h exp %h", d, 32'hFFFF_FFFE); end
    cycle(); peek(5'd9, d); peek(5'd13, c);
    checks++; if (d !== 32'hFFFF_FFFF || c[30] !== 1'b0) begin errors++; $display("FAIL cnt_ff got %h ti=%b exp ffffffff 0", d, c[30]); end
    cycle(); peek(5'd9, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL cnt_wrap got %h exp 0", d); end
    cycle(); peek(5'd9, d); peek(5'd13, c);
    checks++; if (d !== 32'h1 || c[30] !== 1'b1 || int_req !== 1'b1) begin
      errors++; $display("FAIL ti_set got cnt=%h ti=%b irq=%b exp 1 1 1", d, c[30], int_req);
    end
    mtc0(5'd11, 32'h5);
    peek(5'd13, c);
    checks++; if (c[30] !== 1'b0 || int_req !== 1'b0) begin errors++; $display("FAIL ti_clear got ti=%b irq=%b exp 0 0", c[30], int_req); end
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd8);
    cycle();
    mtc0(5'd11, 32'd20);
    peek(5'd9, d); peek(5'd13, c);
    checks++; if (d !== 32'd10 || c[30] !== 1'b0) begin errors++; $display("FAIL clear_wins got cnt=%h ti=%b exp 0000000a 0", d, c[30]); end
  endtask
`else
  task automatic test_timer();
    logic [31:0] d;
    mtc0(5'd9, 32'h1234_5678);
    mtc0(5'd11, 32'h0000_0003);
    mtc0(5'd12, 32'h4000_0001);
    peek(5'd9, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL no_count got %h exp 0", d); end
    peek(5'd11, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL no_compare got %h exp 0", d); end
    peek(5'd12, d);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL no_tie got %h exp %h", d, 32'h0000_0001); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
    if (TIMER) begin
      mtc0(5'd11, 32'd20);
      mtc0(5'd9, 32'd19);
    end
    exc_valid = 1'b1; exc_code = EXC_OV; pc_m = 32'h0000_4000;
    cycle();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++; if ({exl, ie, im, epc} !== '0) begin errors++; $display("FAIL rst_mid_outs got exl=%b ie=%b im=%h epc=%h exp 0", exl, ie, im, epc); end
    peek(5'd13, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_cause got %h exp 0", d); end
    peek(5'd11, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_cmp got %h exp 0", d); end
    cycle();
    peek(5'd9, d);
    checks++; if (d !== (TIMER ? 32'd1 : 32'd0)) begin errors++; $display("FAIL rst_mid_cnt got %h exp %h", d, TIMER ? 32'd1 : 32'd0); end
  endtask

  task automatic test_random();
    int pick;
    for (int i = 0; i < 600; i++) begin
      pick = int'($urandom_range(0, 7));
      case (pick)
        0: addr = 5'd9;
        1: addr = 5'd11;
        2: addr = 5'd12;
        3: addr = 5'd13;
        4: addr = 5'd14;
        5: addr = 5'd15;
        default: addr = 5'($urandom);
      endcase
      wdata     = $urandom;
      we        = ($urandom_range(0, 1) == 1);
      exc_valid = ($urandom_range(0, 7) == 0);
      eret      = ($urandom_range(0, 5) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      bd_m      = 1'($urandom);
      pc_m      = $urandom;
      exc_code  = 5'($urandom);
      hw_int    = N'($urandom);
      cycle();
      checks++; if (epc !== m_epc) begin errors++; $display("FAIL rnd_epc[%0d] got %h exp %h", i, epc, m_epc); end
      checks++; if (exl !== m_sr[1]) begin errors++; $display("FAIL rnd_exl[%0d] got %b exp %b", i, exl, m_sr[1]); end
      checks++; if (ie !== m_sr[0]) begin errors++; $display("FAIL rnd_ie[%0d] got %b exp %b", i, ie, m_sr[0]); end
      checks++; if (im !== m_sr[15:10]) begin errors++; $display("FAIL rnd_im[%0d] got %h exp %h", i, im, m_sr[15:10]); end
      checks++; if (int_req !== m_int_req()) begin errors++; $display("FAIL rnd_irq[%0d] got %b exp %b", i, int_req, m_int_req()); end
      checks++; if (rdata !== m_read(addr)) begin errors++; $display("FAIL rnd_rdata[%0d] addr %0d got %h exp %h", i, addr, rdata, m_read(addr)); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception();
    test_eret();
    test_timer();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
